// File: rtl/p_multiplier.sv
// rtl/p_multiplier.sv - fixed-latency radix-2 shift-add unsigned multiplier with start/done handshake
// Result and done flag are held in DONE so the surrounding array can drain products at its own pace.
module p_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 input_ready,
    output logic                 output_ready,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]     b_sh;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc_next;

    // Accumulator value after the current iteration; also the final product on the last one.
    always_comb begin
        acc_next = acc;
        if (b_sh[0]) begin
            acc_next = acc + a_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            output_ready <= 1'b0;
            product      <= '0;
            a_sh         <= '0;
            b_sh         <= '0;
            acc          <= '0;
            cnt          <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (input_ready) begin
                        a_sh         <= {{WIDTH{1'b0}}, A};
                        b_sh         <= B;
                        acc          <= '0;
                        cnt          <= '0;
                        output_ready <= 1'b0;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    // Always run all WIDTH iterations so every array instance finishes together.
                    acc  <= acc_next;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        product      <= acc_next;
                        output_ready <= 1'b1;
                        state        <= DONE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    output_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p_multiplier.sv
// tb/tb_p_multiplier.sv - self-checking bench for p_multiplier with a queue-based scoreboard
module tb_p_multiplier;

    localparam int WIDTH = 8;

    logic               clk;
    logic               reset;
    logic               input_ready;
    logic               output_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] product;

    int tests_run;
    int tests_failed;
    logic [2*WIDTH-1:0] exp_q[$];

    p_multiplier #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .input_ready (input_ready),
        .output_ready(output_ready),
        .reset       (reset),
        .A           (a),
        .B           (b),
        .product     (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle start; returns half a cycle after the start edge.
    task automatic do_start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input bit push);
        logic [2*WIDTH-1:0] e;
        @(negedge clk);
        a = av;
        b = bv;
        input_ready = 1'b1;
        e = {{WIDTH{1'b0}}, av} * {{WIDTH{1'b0}}, bv};
        if (push) exp_q.push_back(e);
        @(negedge clk);
        input_ready = 1'b0;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
    endtask

    // Counts edges after the start edge until output_ready; returns -1 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!output_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!output_ready) lat = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        input_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (output_ready !== 1'b0 || product !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_state: output_ready=%b product=%h, want 0 / 0000", output_ready, product);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (output_ready !== 1'b0 || product !== 16'h0000) begin
            tests_failed++;
            $display("FAIL idle_hold: output_ready=%b product=%h, want 0 / 0000", output_ready, product);
        end
    endtask

    task automatic test_basic;
        int lat;
        logic [2*WIDTH-1:0] e;
        do_start(8'd3, 8'd5, 1'b1);
        wait_done(lat);
        e = exp_q.pop_front();
        tests_run++;
        if (lat !== 8 || product !== e) begin
            tests_failed++;
            $display("FAIL basic_3x5: latency=%0d product=%0d, want 8 / %0d", lat, product, e);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests_run++;
            if (output_ready !== 1'b1 || product !== e) begin
                tests_failed++;
                $display("FAIL done_hold cycle %0d: output_ready=%b product=%0d, want 1 / %0d", i, output_ready, product, e);
            end
        end
    endtask

    task automatic test_corners;
        logic [WIDTH-1:0] ta[6] = '{8'd255, 8'd0, 8'd1, 8'd128, 8'd200, 8'd171};
        logic [WIDTH-1:0] tb[6] = '{8'd255, 8'd200, 8'd200, 8'd2, 8'd0, 8'd205};
        int lat;
        logic [2*WIDTH-1:0] e;
        for (int i = 0; i < 6; i++) begin
            do_start(ta[i], tb[i], 1'b1);
            tests_run++;
            if (output_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL corner_busy %0d: output_ready=%b, want 0", i, output_ready);
            end
            wait_done(lat);
            e = exp_q.pop_front();
            tests_run++;
            if (lat !== 8 || product !== e) begin
                tests_failed++;
                $display("FAIL corner %0d*%0d: latency=%0d product=%h, want 8 / %h", ta[i], tb[i], lat, product, e);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int n;
        logic [2*WIDTH-1:0] e;
        do_start(8'd7, 8'd9, 1'b1);
        n = 0;
        repeat (2) begin @(negedge clk); n++; end
        a = 8'd2;
        b = 8'd2;
        input_ready = 1'b1;
        @(negedge clk);
        n++;
        input_ready = 1'b0;
        while (!output_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        tests_run++;
        if (n !== 8 || product !== e || output_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_ignore: cycles=%0d product=%0d ready=%b, want 8 / %0d / 1", n, product, output_ready, e);
        end
    endtask

    task automatic test_reset_abort;
        bit seen;
        do_start(8'd10, 8'd10, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (output_ready !== 1'b0 || product !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_abort: output_ready=%b product=%h, want 0 / 0000", output_ready, product);
        end
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (output_ready !== 1'b0 || product !== 16'h0000) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL reset_no_done: spurious completion seen=%b, want 0", seen);
        end
    endtask

    task automatic test_restart;
        int lat;
        bit bad;
        logic [2*WIDTH-1:0] e;
        do_start(8'd3, 8'd5, 1'b1);
        wait_done(lat);
        e = exp_q.pop_front();
        tests_run++;
        if (lat !== 8 || product !== e) begin
            tests_failed++;
            $display("FAIL restart_first: latency=%0d product=%0d, want 8 / %0d", lat, product, e);
        end
        do_start(8'd12, 8'd12, 1'b1);
        tests_run++;
        if (output_ready !== 1'b0 || product !== 16'd15) begin
            tests_failed++;
            $display("FAIL restart_drop: output_ready=%b product=%0d, want 0 / 15", output_ready, product);
        end
        bad = 1'b0;
        lat = 0;
        while (!output_ready && lat < 20) begin
            if (product !== 16'd15) bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        tests_run++;
        if (bad || lat !== 8 || product !== e) begin
            tests_failed++;
            $display("FAIL restart_result: held_ok=%b latency=%0d product=%0d, want 1 / 8 / %0d", !bad, lat, product, e);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [2*WIDTH-1:0] e;
        @(negedge clk);
        a = 8'd4;
        b = 8'd6;
        input_ready = 1'b1;
        exp_q.push_back(16'd24);
        exp_q.push_back(16'd24);
        @(negedge clk);
        wait_done(lat);
        e = exp_q.pop_front();
        tests_run++;
        if (lat !== 8 || product !== e) begin
            tests_failed++;
            $display("FAIL held_start_first: latency=%0d product=%0d, want 8 / %0d", lat, product, e);
        end
        @(negedge clk);
        input_ready = 1'b0;
        tests_run++;
        if (output_ready !== 1'b0 || product !== e) begin
            tests_failed++;
            $display("FAIL held_start_restart: output_ready=%b product=%0d, want 0 / %0d", output_ready, product, e);
        end
        wait_done(lat);
        e = exp_q.pop_front();
        tests_run++;
        if (lat !== 8 || product !== e) begin
            tests_failed++;
            $display("FAIL held_start_second: latency=%0d product=%0d, want 8 / %0d", lat, product, e);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_corners();
        test_busy_ignore();
        test_reset_abort();
        test_restart();
        test_back_to_back();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
